// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg
// Shared types and default sizes for the partial-sum drain sequencer.
//   state_e    : top-level sequencer states (IDLE, SERIAL, XCHG, DIV)
//   tx_phase_e : progress of the outgoing 4-phase handshake
//   *_DEF      : default BW_PSUM / COL / SUM_BW values
package psum_drain_pkg;

   localparam int BW_PSUM_DEF = 20;
   localparam int COL_DEF     = 8;
   localparam int SUM_BW_DEF  = 24;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SERIAL = 2'd1,
      ST_XCHG   = 2'd2,
      ST_DIV    = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      TX_REQ      = 2'd0,
      TX_WAIT_LOW = 2'd1,
      TX_DONE     = 2'd2
   } tx_phase_e;

endpackage

// File: rtl/psum_drain_seq_if.sv
// psum_drain_seq_if
// Bundles the serialized output stream and the peer-sum exchange handshake.
//   nrm_valid/nrm_ready/nrm_data/nrm_last : serialized psum words, one column per beat
//   tx_req/tx_ack/tx_data                 : local sum sent to the peer (4-phase)
//   rx_req/rx_ack/rx_data                 : peer sum received (4-phase)
// Modports: master = sequencer side, slave = downstream consumer / peer side.
interface psum_drain_seq_if
   import psum_drain_pkg::*;
#(
   parameter int BW_PSUM = BW_PSUM_DEF,
   parameter int SUM_BW  = SUM_BW_DEF
);

   logic               nrm_valid;
   logic               nrm_ready;
   logic [BW_PSUM-1:0] nrm_data;
   logic               nrm_last;

   logic               tx_req;
   logic               tx_ack;
   logic [SUM_BW-1:0]  tx_data;

   logic               rx_req;
   logic               rx_ack;
   logic [SUM_BW-1:0]  rx_data;

   modport master (
      output nrm_valid, nrm_data, nrm_last, tx_req, tx_data, rx_ack,
      input  nrm_ready, tx_ack, rx_req, rx_data
   );

   modport slave (
      input  nrm_valid, nrm_data, nrm_last, tx_req, tx_data, rx_ack,
      output nrm_ready, tx_ack, rx_req, rx_data
   );

endinterface

// File: rtl/hs4_rx.sv
// hs4_rx
// Receiving half of a 4-phase handshake: captures one value per row,
// acknowledges it, and flags completion once the sender drops its request.
//   clk, reset    : clock, asynchronous active-low reset
//   enable        : handshake may progress (sequencer in SERIAL or XCHG)
//   clear         : forget any held value, start a fresh exchange
//   rx_req/rx_ack : handshake pair, rx_data captured on the first request
//   value         : captured peer value
//   done          : handshake complete (ack dropped after request fell)
module hs4_rx #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         clear,
   input  logic         rx_req,
   input  logic [W-1:0] rx_data,
   output logic         rx_ack,
   output logic [W-1:0] value,
   output logic         done
);

   logic held;

   // Capture once per row; a request arriving while a value is already held
   // is left pending so a second peer word can never overwrite the first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         held   <= 1'b0;
         rx_ack <= 1'b0;
         done   <= 1'b0;
         value  <= '0;
      end else if (clear) begin
         held   <= 1'b0;
         rx_ack <= 1'b0;
         done   <= 1'b0;
         value  <= '0;
      end else if (enable) begin
         if (!held && rx_req) begin
            value  <= rx_data;
            held   <= 1'b1;
            rx_ack <= 1'b1;
         end else if (rx_ack && !rx_req) begin
            rx_ack <= 1'b0;
            done   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/psum_drain_seq.sv
// psum_drain_seq
// Drains one row of partial sums: serializes COL words onto a valid/ready
// stream, accumulates their absolute values, optionally swaps the local sum
// with a peer over 4-phase handshakes, then pulses div with the total.
//   clk, reset          : clock, asynchronous active-low reset
//   load, load_data     : row-load strobe and packed row (column 0 in LSBs)
//   solo                : skip the peer exchange for this row
//   bus (master)        : nrm_* stream, tx_* and rx_* peer handshakes
//   div                 : one-cycle pulse when sum_total is updated
//   sum_total           : local (+ peer) sum, SUM_BW+1 bits, never wraps
//   busy                : sequencer not idle
//   drop_err            : sticky, a load arrived while busy
// Build option: define PSUM_DRAIN_PEER_EN to include the XCHG state and the
// tx/rx handshakes; otherwise every row goes straight from SERIAL to DIV.
module psum_drain_seq
   import psum_drain_pkg::*;
#(
   parameter int BW_PSUM = BW_PSUM_DEF,
   parameter int COL     = COL_DEF,
   parameter int SUM_BW  = SUM_BW_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [COL*BW_PSUM-1:0] load_data,
   input  logic                   solo,
   psum_drain_seq_if.master       bus,
   output logic                   div,
   output logic [SUM_BW:0]        sum_total,
   output logic                   busy,
   output logic                   drop_err
);

   localparam int CW = $clog2(COL);
   localparam logic [CW-1:0] LAST_COL = CW'(COL - 1);

   state_e                        state;
   logic [COL-1:0][BW_PSUM-1:0]   row;
   logic [CW-1:0]                 col_cnt;
   logic [SUM_BW-1:0]             local_sum;
   logic [BW_PSUM-1:0]            cur_word;
   logic [BW_PSUM-1:0]            word_abs;
   logic [SUM_BW-1:0]             next_local;
   logic                          skip_peer;
   logic                          xchg_done;
   logic [SUM_BW:0]               peer_total;

   assign cur_word      = row[col_cnt];
   assign bus.nrm_data  = cur_word;
   assign bus.nrm_valid = (state == ST_SERIAL);
   assign bus.nrm_last  = (state == ST_SERIAL) && (col_cnt == LAST_COL);
   assign busy          = (state != ST_IDLE);
   assign div           = (state == ST_DIV);

   // Magnitude treated as unsigned so the most negative word maps to
   // 2^(BW_PSUM-1) exactly instead of overflowing back to itself.
   assign word_abs   = cur_word[BW_PSUM-1] ? (~cur_word + BW_PSUM'(1)) : cur_word;
   assign next_local = local_sum + SUM_BW'(word_abs);

`ifdef PSUM_DRAIN_PEER_EN
   tx_phase_e         tx_phase;
   logic              rx_done;
   logic [SUM_BW-1:0] rx_value;

   assign skip_peer   = solo;
   assign bus.tx_req  = (state == ST_XCHG) && (tx_phase == TX_REQ);
   assign bus.tx_data = local_sum;
   assign xchg_done   = (tx_phase == TX_DONE) && rx_done;
   assign peer_total  = (SUM_BW+1)'(local_sum) + (SUM_BW+1)'(rx_value);

   // Outgoing handshake only runs in XCHG; it restarts with every new row.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_phase <= TX_REQ;
      end else if ((state == ST_IDLE) && load) begin
         tx_phase <= TX_REQ;
      end else if (state == ST_XCHG) begin
         case (tx_phase)
            TX_REQ:      if (bus.tx_ack)  tx_phase <= TX_WAIT_LOW;
            TX_WAIT_LOW: if (!bus.tx_ack) tx_phase <= TX_DONE;
            default:     tx_phase <= tx_phase;
         endcase
      end
   end

   // The peer may start sending as soon as serialization begins, so the
   // receiver is live in both SERIAL and XCHG.
   hs4_rx #(.W(SUM_BW)) u_rx (
      .clk     (clk),
      .reset   (reset),
      .enable  ((state == ST_SERIAL) || (state == ST_XCHG)),
      .clear   ((state == ST_IDLE) && load),
      .rx_req  (bus.rx_req),
      .rx_data (bus.rx_data),
      .rx_ack  (bus.rx_ack),
      .value   (rx_value),
      .done    (rx_done)
   );
`else
   logic unused_peer;

   assign skip_peer   = 1'b1;
   assign bus.tx_req  = 1'b0;
   assign bus.tx_data = '0;
   assign bus.rx_ack  = 1'b0;
   assign xchg_done   = 1'b0;
   assign peer_total  = (SUM_BW+1)'(local_sum);
   assign unused_peer = ^{solo, bus.tx_ack, bus.rx_req, bus.rx_data};
`endif

   // Main sequencer. sum_total is written only on entry to DIV so it holds
   // the last result until the next row finishes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         row       <= '0;
         col_cnt   <= '0;
         local_sum <= '0;
         sum_total <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load) begin
                  row       <= load_data;
                  local_sum <= '0;
                  col_cnt   <= '0;
                  state     <= ST_SERIAL;
               end
            end
            ST_SERIAL: begin
               if (bus.nrm_ready) begin
                  local_sum <= next_local;
                  if (col_cnt == LAST_COL) begin
                     if (skip_peer) begin
                        sum_total <= (SUM_BW+1)'(next_local);
                        state     <= ST_DIV;
                     end else begin
                        state <= ST_XCHG;
                     end
                  end else begin
                     col_cnt <= col_cnt + CW'(1);
                  end
               end
            end
            ST_XCHG: begin
               if (xchg_done) begin
                  sum_total <= peer_total;
                  state     <= ST_DIV;
               end
            end
            ST_DIV: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // A load is only honoured in IDLE; anything else is remembered as an error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_err <= 1'b0;
      end else if (load && (state != ST_IDLE)) begin
         drop_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_psum_drain_seq.sv
// tb_psum_drain_seq
// Directed bench for psum_drain_seq (BW_PSUM=20, COL=8, SUM_BW=24).
// Follows the build option PSUM_DRAIN_PEER_EN: with it defined the peer
// exchange is exercised, otherwise the tx/rx side must stay quiet.
module tb_psum_drain_seq;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          load = 1'b0;
   logic          solo = 1'b0;
   logic [159:0]  load_data = '0;
   logic          div;
   logic [24:0]   sum_total;
   logic          busy;
   logic          drop_err;

   logic [19:0]   words [8];
   int            total = 0;
   int            bad = 0;

   psum_drain_seq_if #(.BW_PSUM(20), .SUM_BW(24)) bus ();

   psum_drain_seq #(.BW_PSUM(20), .COL(8), .SUM_BW(24)) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_data (load_data),
      .solo      (solo),
      .bus       (bus),
      .div       (div),
      .sum_total (sum_total),
      .busy      (busy),
      .drop_err  (drop_err)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard stop in case the sequence itself ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [159:0] build_row();
      logic [159:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[i*20 +: 20] = words[i];
      return r;
   endfunction

   // One-cycle load strobe in IDLE; returns in the first SERIAL cycle
   task automatic apply_stimulus(input logic solo_v);
      load_data = build_row();
      solo      = solo_v;
      load      = 1'b1;
      tick();
      load      = 1'b0;
   endtask

   // Streams the loaded row with nrm_ready held high, checking every beat
   task automatic stream_words(input string tag);
      bus.nrm_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check_output({tag, "_data"}, 32'(bus.nrm_data), 32'(words[k]));
         check_output({tag, "_last"}, 32'(bus.nrm_last), 32'(k == 7));
         tick();
      end
   endtask

   task automatic wait_div(input int max, input string tag);
      int n;
      n = 0;
      while (div !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      check_output(tag, 32'(div), 32'd1);
   endtask

`ifdef PSUM_DRAIN_PEER_EN
   // Full tx-then-rx exchange starting in the first XCHG cycle
   task automatic peer_exchange(input logic [23:0] local_exp, input logic [23:0] peer, input logic [24:0] total_exp);
      check_output("px_tx_req", 32'(bus.tx_req), 32'd1);
      check_output("px_tx_data", 32'(bus.tx_data), 32'(local_exp));
      bus.tx_ack = 1'b1;
      tick();
      check_output("px_tx_drop", 32'(bus.tx_req), 32'd0);
      bus.tx_ack = 1'b0;
      tick();
      bus.rx_req  = 1'b1;
      bus.rx_data = peer;
      tick();
      check_output("px_rx_ack", 32'(bus.rx_ack), 32'd1);
      bus.rx_req = 1'b0;
      tick();
      check_output("px_rx_ack_drop", 32'(bus.rx_ack), 32'd0);
      wait_div(5, "px_div");
      check_output("px_sum", 32'(sum_total), 32'(total_exp));
   endtask
`endif

   initial begin
      logic [3:0] pat;
      int         acc;
      int         c;

      bus.nrm_ready = 1'b0;
      bus.tx_ack    = 1'b0;
      bus.rx_req    = 1'b0;
      bus.rx_data   = '0;

      // Reset values
      #1;
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_valid", 32'(bus.nrm_valid), 32'd0);
      check_output("rst_data", 32'(bus.nrm_data), 32'd0);
      check_output("rst_sum", 32'(sum_total), 32'd0);
      check_output("rst_div", 32'(div), 32'd0);
      check_output("rst_drop", 32'(drop_err), 32'd0);
      check_output("rst_tx_req", 32'(bus.tx_req), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      tick();

      // Words 1..8, first word one cycle after load, peer adds 100
      $display("[TB] row 1..8 with exchange");
      words = '{20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8};
      apply_stimulus(1'b0);
      check_output("t1_busy", 32'(busy), 32'd1);
      check_output("t1_valid", 32'(bus.nrm_valid), 32'd1);
      stream_words("t1");
`ifdef PSUM_DRAIN_PEER_EN
      check_output("t1_no_early_div", 32'(div), 32'd0);
      peer_exchange(24'd36, 24'd100, 25'd136);
`else
      wait_div(0, "t1_div");
      check_output("t1_sum", 32'(sum_total), 32'd36);
      check_output("t1_tx_req", 32'(bus.tx_req), 32'd0);
      check_output("t1_tx_data", 32'(bus.tx_data), 32'd0);
`endif
      tick();
      check_output("t1_div_once", 32'(div), 32'd0);
      check_output("t1_idle", 32'(busy), 32'd0);
      check_output("t1_drop_clear", 32'(drop_err), 32'd0);

      // All -1, solo; loads during SERIAL and DIV must be dropped
      $display("[TB] row of -1, solo, dropped loads");
      words = '{default: 20'hFFFFF};
      apply_stimulus(1'b1);
      bus.nrm_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check_output("t2_data", 32'(bus.nrm_data), 32'hFFFFF);
         check_output("t2_no_tx", 32'(bus.tx_req), 32'd0);
         if (k == 4) check_output("t2_drop_serial", 32'(drop_err), 32'd1);
         if (k == 3) begin
            load_data = {20'd8, 20'd7, 20'd6, 20'd5, 20'd4, 20'd3, 20'd2, 20'd1};
            load      = 1'b1;
         end
         tick();
         load = 1'b0;
      end
      wait_div(0, "t2_div");
      check_output("t2_sum", 32'(sum_total), 32'd8);
      load_data = {20'd8, 20'd7, 20'd6, 20'd5, 20'd4, 20'd3, 20'd2, 20'd1};
      load      = 1'b1;
      tick();
      load = 1'b0;
      check_output("t2_div_load_ignored", 32'(busy), 32'd0);
      check_output("t2_drop_sticky", 32'(drop_err), 32'd1);

      // 0x80000 words with ready pattern 1,0,0,1
      $display("[TB] stalled stream of 0x80000");
      words = '{default: 20'h80000};
      apply_stimulus(1'b1);
      pat = 4'b1001;
      acc = 0;
      c   = 0;
      while (acc < 8 && c < 64) begin
         bus.nrm_ready = pat[c % 4];
         check_output("t3_valid", 32'(bus.nrm_valid), 32'd1);
         check_output("t3_data", 32'(bus.nrm_data), 32'h80000);
         check_output("t3_last", 32'(bus.nrm_last), 32'(acc == 7));
         if (bus.nrm_ready) acc++;
         tick();
         c++;
      end
      bus.nrm_ready = 1'b1;
      check_output("t3_accepted", 32'(acc), 32'd8);
      check_output("t3_cycles", 32'(c), 32'd16);
      wait_div(0, "t3_div");
      check_output("t3_sum", 32'(sum_total), 32'h400000);
      check_output("t3_drop_still", 32'(drop_err), 32'd1);
      tick();

      // Mixed signs; peer sends 55 early during SERIAL
      $display("[TB] mixed signs, early peer word");
      words = '{20'hFFFFD, 20'd5, 20'd0, 20'hFFFFF, 20'd7, 20'd2, 20'hFFFF8, 20'd4};
      apply_stimulus(1'b0);
      bus.rx_req  = 1'b1;
      bus.rx_data = 24'd55;
      bus.nrm_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check_output("t4_data", 32'(bus.nrm_data), 32'(words[k]));
`ifdef PSUM_DRAIN_PEER_EN
         if (k == 1) begin
            check_output("t4_rx_ack_serial", 32'(bus.rx_ack), 32'd1);
            bus.rx_req = 1'b0;
         end
         if (k == 2) check_output("t4_rx_ack_drop", 32'(bus.rx_ack), 32'd0);
`else
         if (k == 1) check_output("t4_rx_ignored", 32'(bus.rx_ack), 32'd0);
`endif
         tick();
      end
`ifdef PSUM_DRAIN_PEER_EN
      check_output("t4_wait_tx", 32'(div), 32'd0);
      check_output("t4_tx_data", 32'(bus.tx_data), 32'd30);
      bus.tx_ack = 1'b1;
      tick();
      bus.tx_ack = 1'b0;
      tick();
      wait_div(3, "t4_div");
      check_output("t4_sum", 32'(sum_total), 32'd85);
`else
      bus.rx_req = 1'b0;
      wait_div(0, "t4_div");
      check_output("t4_sum", 32'(sum_total), 32'd30);
`endif
      tick();

      // Reset in the middle of a row, then a clean row afterwards
      $display("[TB] reset mid-row");
      words = '{20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8};
      apply_stimulus(1'b0);
`ifdef PSUM_DRAIN_PEER_EN
      stream_words("t5a");
      bus.rx_req  = 1'b1;
      bus.rx_data = 24'd9;
      tick();
      check_output("t5_tx_req_pre", 32'(bus.tx_req), 32'd1);
      check_output("t5_rx_ack_pre", 32'(bus.rx_ack), 32'd1);
`else
      bus.nrm_ready = 1'b1;
      repeat (3) tick();
`endif
      reset = 1'b0;
      #1;
      check_output("t5_tx_req_rst", 32'(bus.tx_req), 32'd0);
      check_output("t5_rx_ack_rst", 32'(bus.rx_ack), 32'd0);
      check_output("t5_busy_rst", 32'(busy), 32'd0);
      check_output("t5_valid_rst", 32'(bus.nrm_valid), 32'd0);
      check_output("t5_drop_rst", 32'(drop_err), 32'd0);
      check_output("t5_sum_rst", 32'(sum_total), 32'd0);
      bus.rx_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      apply_stimulus(1'b0);
      stream_words("t5b");
`ifdef PSUM_DRAIN_PEER_EN
      peer_exchange(24'd36, 24'd100, 25'd136);
`else
      wait_div(0, "t5_div");
      check_output("t5_sum", 32'(sum_total), 32'd36);
`endif
      tick();
      check_output("t5_idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/psum_drain_seq.md
PSUM_DRAIN_SEQ -- requirements
Module: psum_drain_seq

Interface
REQ-001 SHALL have parameters: BW_PSUM, default 20, psum word width; COL, default 8, columns per row (at least 2); SUM_BW, default 24, sum width (at least BW_PSUM+clog2(COL)).
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: load  in  1  row-load strobe; load_data  in  COL*BW_PSUM  packed row, column 0 in bits [BW_PSUM-1:0]; solo  in  1  skip peer exchange.
REQ-004 SHALL have ports: nrm_valid  out  1; nrm_ready  in  1; nrm_data  out  BW_PSUM  serialized word; nrm_last  out  1  final column.
REQ-005 SHALL have ports: tx_req  out  1; tx_ack  in  1; tx_data  out  SUM_BW  local sum to peer; rx_req  in  1; rx_ack  out  1; rx_data  in  SUM_BW  peer sum.
REQ-006 SHALL have ports: div  out  1  one-cycle sum-ready pulse; sum_total  out  SUM_BW+1  local+peer sum; busy  out  1; drop_err  out  1  sticky overflow of load.

Function
REQ-007 SHALL implement states IDLE, SERIAL, XCHG, DIV; busy=1 in every state except IDLE.
REQ-008 In IDLE, load=1 SHALL capture load_data, clear local sum, column count and rx flag, and go to SERIAL next cycle.
REQ-009 In SERIAL, nrm_valid SHALL be 1 and nrm_data SHALL equal column k; k SHALL advance only on nrm_valid&nrm_ready; nrm_data SHALL hold stable while stalled.
REQ-010 Each accepted word SHALL add its two's-complement absolute value (unsigned, so |-2^(BW_PSUM-1)| is exact) to the local sum.
REQ-011 nrm_last SHALL be 1 when k=COL-1; its accepted transfer SHALL move to XCHG, or to DIV if solo=1 (solo sampled at that transfer).
REQ-012 First word latency: load at cycle N SHALL give nrm_valid at cycle N+1.
REQ-013 In XCHG, the tx side SHALL run a 4-phase handshake: tx_req=1 with tx_data=local sum; after tx_ack=1, drop tx_req; done when tx_ack=0.
REQ-014 The rx side SHALL be serviced in SERIAL and XCHG: on rx_req=1 with no value held, capture rx_data and set rx_ack=1; drop rx_ack when rx_req=0; the rx side is done after that drop.
REQ-015 rx_req in IDLE or DIV SHALL NOT be acknowledged and SHALL stay pending.
REQ-016 XCHG SHALL go to DIV on the first cycle both tx and rx are done, in either order or the same cycle.
REQ-017 In DIV, div SHALL be 1 for exactly one cycle; sum_total SHALL be local+peer (local only if solo) and SHALL hold until the next DIV; the next state is IDLE.
REQ-018 load while busy=1 SHALL be ignored and SHALL set drop_err, which stays set until reset.
REQ-019 sum_total SHALL be SUM_BW+1 bits wide and SHALL never wrap.

Reset
REQ-020 reset=0 SHALL asynchronously force IDLE; nrm_valid, nrm_last, tx_req, rx_ack, div, busy and drop_err to 0; nrm_data, tx_data, sum_total and internal sums to 0.
REQ-021 Reset mid-handshake SHALL drop tx_req and rx_ack immediately; a held peer value SHALL be discarded.

Configuration
REQ-022 With PSUM_DRAIN_PEER_EN defined, SHALL implement XCHG and the tx/rx handshake logic.
REQ-023 With PSUM_DRAIN_PEER_EN undefined, SHALL omit XCHG and the handshake logic: SERIAL goes to DIV; tx_req, rx_ack and tx_data tie to 0; rx inputs are ignored; sum_total is the local sum; the port list is unchanged.

Structure
REQ-024 Package psum_drain_pkg SHALL hold the state enum type and the default BW_PSUM/COL/SUM_BW constants.
REQ-025 The rx half of the handshake (capture, ack, hold, done flag) SHALL be a sub-module hs4_rx, instantiated only under PSUM_DRAIN_PEER_EN.

Verification
REQ-026 COL=8, load words 1..8, nrm_ready=1, peer sends 100 after tx done -> nrm_data 1..8 at cycles N+1..N+8, nrm_last at N+8, div once, sum_total=136.
REQ-027 All words -1, solo=1 -> no tx_req, div at cycle after last transfer, sum_total=8.
REQ-028 nrm_ready toggled 1,0,0,1 per cycle, words 0x80000 (BW_PSUM=20) -> data stable during stalls, sum_total local part=8*0x80000.
REQ-029 rx_req from peer (value 55) during SERIAL, before local tx -> rx_ack during SERIAL, div after tx completes, sum_total=local+55.
REQ-030 load at DIV cycle and during SERIAL -> both ignored, drop_err=1; the next load in IDLE is accepted normally.
REQ-031 reset=0 while tx_req=1 in XCHG -> tx_req, rx_ack and busy=0 in the same cycle; after reset release, a new load completes a normal exchange.
